alu_exec_unit: RTL and testbench
================================

// Module: alu_exec_unit
// PURPOSE
//  Parametrised RV32I/M execute stage: decodes aluOp/funct3/funct7 internally and produces a registered result.
//  Single-cycle ops for full RV32I ALU set; optional iterative shift-add MUL (low half).
//  valid/ready handshake on both sides so the stage can stall the multi-cycle control path.
// PARAMETERS
//  WIDTH   32  operand/result width (>=8); shift amount = b[$clog2(WIDTH)-1:0]
//  MUL_EN  1   1: MUL supported (WIDTH-cycle iterative); 0: MUL encoding executes as ADD
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      operation request valid
//  in_ready   out  1      unit can accept request this cycle
//  alu_op     in   2      00 ADD (lw/sw), 01 SUB (branch), 10 funct-decoded, 11 PASS_B (lui)
//  f3         in   3      instruction funct3
//  f7         in   1      instruction bit 30 (sub/sra select)
//  f7_m       in   1      instruction bit 25 (M-extension select)
//  a, b       in   WIDTH  operands
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts result
//  result     out  WIDTH  registered result
//  zero       out  1      registered (result == 0)
//  busy       out  1      MUL iteration in progress
// BEHAVIOUR
//  Decode (alu_op=10): f3 000 ADD/SUB(f7=1); 001 SLL; 010 SLT (signed); 011 SLTU; 100 XOR;
//   101 SRL/SRA(f7=1); 110 OR; 111 AND. f7_m=1 & f3=000 & MUL_EN -> MUL; f7_m=1 other f3 -> ADD.
//  SLT/SLTU result = {WIDTH-1 zeros, flag}. ADD/SUB/MUL wrap modulo 2^WIDTH; MUL = low WIDTH bits.
//  Reset (async, rst_n=0): state=IDLE, out_valid=0, result=0, zero=1, busy=0, counter=0.
//  in_ready = (state==IDLE) & (!out_valid | out_ready). Accept = in_valid & in_ready.
//  FSM IDLE: accept non-MUL -> result/zero loaded same edge, out_valid=1 next cycle (latency 1),
//   stay IDLE; back-to-back one op/cycle when out_ready held high.
//  IDLE: accept MUL -> latch a (multiplicand), b (multiplier), acc=0, cnt=0, go MUL, busy=1.
//  MUL: each cycle: if mplier[0] acc+=mcand; mcand<<=1; mplier>>=1; cnt++.
//   After WIDTH iterations (cnt==WIDTH-1 edge) -> result=acc, out_valid=1, busy=0, IDLE.
//   MUL latency WIDTH+1 cycles from accept to out_valid. in_ready=0 throughout MUL.
//  Output hold: while out_valid & !out_ready, result/zero stable, in_ready=0.
//  out_valid clears on out_valid & out_ready unless a new op is accepted same edge (then reloads).
//  Operands not sampled outside accept edge; changes on a/b during MUL have no effect.
//  Reset asserted mid-MUL: iteration aborted, no out_valid emitted, IDLE on release.
//  MUL_EN=0: MUL state unreachable, busy tied 0.
// TESTING (WIDTH=32 unless noted)
//  alu_op=10 f3=000 f7=1 a=5 b=7, out_ready=1 -> next cycle out_valid=1, result=32'hFFFF_FFFE, zero=0
//  f3=101 f7=1 a=32'h8000_0000 b=4 -> 32'hF800_0000; f7=0 -> 32'h0800_0000; f3=011 a=-1 b=1 -> 0, zero=1
//  MUL a=32'd12345 b=32'd6789 -> busy 32 cycles, in_ready=0, then result=32'd83810205 exactly 33 cycles after accept
//  out_ready=0 after ADD 3+4 -> result=7 held, in_ready=0 for 5 cycles; out_ready=1 -> next op accepted same edge
//  rst_n low at MUL cycle 10 -> out_valid=0, zero=1, busy=0 immediately; after release next ADD 1+1 -> 2 in 1 cycle
//  WIDTH=8 MUL_EN=1: a=8'hFF b=8'h02 -> result=8'hFE after 9 cycles; MUL_EN=0 same op -> 8'h01 in 1 cycle

Source files
------------

// File: rtl/alu_exec_unit.sv
// RV32I/M execute stage: decodes alu_op/funct fields, produces a registered result with
// valid/ready handshakes, and optionally runs an iterative shift-add multiply (low half).
module alu_exec_unit #(
    parameter int WIDTH  = 32,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       alu_op,
    input  logic [2:0]       f3,
    input  logic             f7,
    input  logic             f7_m,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy
);

    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);
    localparam logic [SHW-1:0] CNT_ONE  = SHW'(1);

    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR,
        OP_SRL, OP_SRA, OP_OR, OP_AND, OP_PASSB, OP_MUL
    } op_e;

    typedef enum logic {S_IDLE, S_MUL} state_e;

    state_e           state, state_next;
    op_e              op;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] mcand, mplier, acc, acc_next;
    logic [SHW-1:0]   cnt;
    logic [SHW-1:0]   shamt;
    logic             accept;

    assign shamt    = b[SHW-1:0];
    assign in_ready = (state == S_IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign busy     = MUL_EN && (state == S_MUL);
    assign acc_next = mplier[0] ? acc + mcand : acc;

    // NOTE: every variable written in an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        op = OP_ADD;
        unique case (alu_op)
            2'b00: op = OP_ADD;
            2'b01: op = OP_SUB;
            2'b11: op = OP_PASSB;
            default: begin
                if (f7_m) begin
                    op = (f3 == 3'b000 && MUL_EN) ? OP_MUL : OP_ADD;
                end else begin
                    unique case (f3)
                        3'b000: op = f7 ? OP_SUB : OP_ADD;
                        3'b001: op = OP_SLL;
                        3'b010: op = OP_SLT;
                        3'b011: op = OP_SLTU;
                        3'b100: op = OP_XOR;
                        3'b101: op = f7 ? OP_SRA : OP_SRL;
                        3'b110: op = OP_OR;
                        default: op = OP_AND;
                    endcase
                end
            end
        endcase
    end

    always_comb begin
        alu_res = a + b;
        case (op)
            OP_SUB:   alu_res = a - b;
            OP_SLL:   alu_res = a << shamt;
            OP_SLT:   alu_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            OP_SLTU:  alu_res = {{(WIDTH-1){1'b0}}, a < b};
            OP_XOR:   alu_res = a ^ b;
            OP_SRL:   alu_res = a >> shamt;
            OP_SRA:   alu_res = $signed(a) >>> shamt;
            OP_OR:    alu_res = a | b;
            OP_AND:   alu_res = a & b;
            OP_PASSB: alu_res = b;
            default:  alu_res = a + b;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (accept && op == OP_MUL) state_next = S_MUL;
            S_MUL:   if (cnt == CNT_LAST) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    // Datapath registers are few and small, so they all take the reset rather than relying on
    // the FSM to mask stale multiply state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b1;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            cnt       <= '0;
        end else if (state == S_IDLE) begin
            if (accept) begin
                if (op == OP_MUL) begin
                    mcand     <= a;
                    mplier    <= b;
                    acc       <= '0;
                    cnt       <= '0;
                    out_valid <= 1'b0;
                end else begin
                    result    <= alu_res;
                    zero      <= (alu_res == '0);
                    out_valid <= 1'b1;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end else begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CNT_ONE;
            // Final iteration folds its partial product straight into the result.
            if (cnt == CNT_LAST) begin
                result    <= acc_next;
                zero      <= (acc_next == '0);
                out_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: vector table for single-cycle ops plus hand-written
// sequences for MUL latency, output hold, reset mid-multiply and 8-bit variants.
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, out_ready;
    logic [1:0]  alu_op;
    logic [2:0]  f3;
    logic        f7, f7_m;
    logic [31:0] a, b;
    logic        in_ready, out_valid, zero, busy;
    logic [31:0] result;

    logic        in_valid8;
    logic [7:0]  a8, b8;
    logic        in_ready8, out_valid8, zero8, busy8;
    logic [7:0]  result8;
    logic        in_ready8n, out_valid8n, zero8n, busy8n;
    logic [7:0]  result8n;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_exec_unit #(.WIDTH(32), .MUL_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .f3(f3), .f7(f7), .f7_m(f7_m), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .zero(zero), .busy(busy)
    );

    alu_exec_unit #(.WIDTH(8), .MUL_EN(1'b1)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .alu_op(alu_op), .f3(f3), .f7(f7), .f7_m(f7_m), .a(a8), .b(b8),
        .out_valid(out_valid8), .out_ready(1'b0), .result(result8),
        .zero(zero8), .busy(busy8)
    );

    alu_exec_unit #(.WIDTH(8), .MUL_EN(1'b0)) dut8n (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8n),
        .alu_op(alu_op), .f3(f3), .f7(f7), .f7_m(f7_m), .a(a8), .b(b8),
        .out_valid(out_valid8n), .out_ready(1'b0), .result(result8n),
        .zero(zero8n), .busy(busy8n)
    );

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic        f7m;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [1:0] op, input logic [2:0] ff3, input logic ff7,
                          input logic ff7m, input logic [31:0] va, input logic [31:0] vb);
        alu_op = op; f3 = ff3; f7 = ff7; f7_m = ff7m; a = va; b = vb;
    endtask

    initial begin
        vecs[0]  = '{"sub",        2'b10, 3'b000, 1'b1, 1'b0, 32'd5,          32'd7,          32'hFFFF_FFFE};
        vecs[1]  = '{"sra",        2'b10, 3'b101, 1'b1, 1'b0, 32'h8000_0000,  32'd4,          32'hF800_0000};
        vecs[2]  = '{"srl",        2'b10, 3'b101, 1'b0, 1'b0, 32'h8000_0000,  32'd4,          32'h0800_0000};
        vecs[3]  = '{"sltu_zero",  2'b10, 3'b011, 1'b0, 1'b0, 32'hFFFF_FFFF,  32'd1,          32'd0};
        vecs[4]  = '{"slt_neg",    2'b10, 3'b010, 1'b0, 1'b0, 32'hFFFF_FFFF,  32'd1,          32'd1};
        vecs[5]  = '{"sll_mask",   2'b10, 3'b001, 1'b0, 1'b0, 32'd1,          32'd33,         32'd2};
        vecs[6]  = '{"xor",        2'b10, 3'b100, 1'b0, 1'b0, 32'hF0F0_F0F0,  32'h0FF0_0FF0,  32'hFF00_FF00};
        vecs[7]  = '{"or",         2'b10, 3'b110, 1'b0, 1'b0, 32'h1234_0000,  32'h0000_5678,  32'h1234_5678};
        vecs[8]  = '{"and",        2'b10, 3'b111, 1'b0, 1'b0, 32'hFFFF_0000,  32'h0F0F_0F0F,  32'h0F0F_0000};
        vecs[9]  = '{"add_wrap",   2'b00, 3'b111, 1'b1, 1'b0, 32'hFFFF_FFFF,  32'd1,          32'd0};
        vecs[10] = '{"sub_op01",   2'b01, 3'b000, 1'b0, 1'b0, 32'd3,          32'd5,          32'hFFFF_FFFE};
        vecs[11] = '{"pass_b",     2'b11, 3'b000, 1'b0, 1'b0, 32'h0000_1234,  32'hDEAD_BEEF,  32'hDEAD_BEEF};
        vecs[12] = '{"m_other_f3", 2'b10, 3'b100, 1'b0, 1'b1, 32'd10,         32'd20,         32'd30};
        vecs[13] = '{"add_ovf",    2'b10, 3'b000, 1'b0, 1'b0, 32'h7FFF_FFFF,  32'd1,          32'h8000_0000};
        vecs[14] = '{"srl_31",     2'b10, 3'b101, 1'b0, 1'b0, 32'h8000_0000,  32'd31,         32'd1};
        vecs[15] = '{"sltu_one",   2'b10, 3'b011, 1'b0, 1'b0, 32'd1,          32'hFFFF_FFFF,  32'd1};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_valid8 = 1'b0;
        a8 = '0; b8 = '0;
        set_op(2'b00, 3'b000, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (3) step();
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_result",    result,             32'd0);
        check("rst_zero",      {31'd0, zero},      32'd1);
        check("rst_busy",      {31'd0, busy},      32'd0);
        rst_n = 1'b1;
        step();
        check("rst_in_ready",  {31'd0, in_ready},  32'd1);

        // Back-to-back single-cycle ops with out_ready held high.
        for (int i = 0; i < 16; i++) begin
            set_op(vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].f7m, vecs[i].a, vecs[i].b);
            in_valid = 1'b1;
            #1;
            check({vecs[i].name, "_in_ready"}, {31'd0, in_ready}, 32'd1);
            step();
            check({vecs[i].name, "_valid"}, {31'd0, out_valid}, 32'd1);
            check(vecs[i].name, result, vecs[i].exp);
            check({vecs[i].name, "_zero"}, {31'd0, zero}, {31'd0, vecs[i].exp == 32'd0});
        end
        in_valid = 1'b0;
        step();
        check("drain_valid", {31'd0, out_valid}, 32'd0);

        // 32-bit MUL: latency, busy window, operand isolation.
        begin
            int edges = 0;
            int busy_cnt = 0;
            int rdy_seen = 0;
            set_op(2'b10, 3'b000, 1'b0, 1'b1, 32'd12345, 32'd6789);
            in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            a = 32'hFFFF_FFFF; b = 32'h1234_5678;
            while (!out_valid && edges < 100) begin
                if (busy) busy_cnt++;
                if (in_ready) rdy_seen++;
                step();
                edges++;
            end
            check("mul_latency",  edges + 1,          32'd33);
            check("mul_busy_cyc", busy_cnt,           32'd32);
            check("mul_in_ready", rdy_seen,           32'd0);
            check("mul_result",   result,             32'd83810205);
            check("mul_busy_end", {31'd0, busy},      32'd0);
            step();
            check("mul_consumed", {31'd0, out_valid}, 32'd0);
        end

        // Output hold under back-pressure, then accept on the releasing edge.
        out_ready = 1'b0;
        set_op(2'b00, 3'b000, 1'b0, 1'b0, 32'd3, 32'd4);
        in_valid = 1'b1;
        step();
        set_op(2'b00, 3'b000, 1'b0, 1'b0, 32'd10, 32'd10);
        for (int i = 0; i < 5; i++) begin
            check("hold_result",   result,             32'd7);
            check("hold_valid",    {31'd0, out_valid}, 32'd1);
            check("hold_in_ready", {31'd0, in_ready},  32'd0);
            step();
        end
        out_ready = 1'b1;
        #1;
        check("release_in_ready", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        check("release_result", result,             32'd20);
        check("release_valid",  {31'd0, out_valid}, 32'd1);
        step();

        // Reset asserted in the middle of a multiply.
        begin
            int spurious = 0;
            set_op(2'b10, 3'b000, 1'b0, 1'b1, 32'd12345, 32'd6789);
            in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            repeat (10) step();
            check("mid_busy", {31'd0, busy}, 32'd1);
            rst_n = 1'b0;
            #1;
            check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
            check("mid_rst_zero",  {31'd0, zero},      32'd1);
            check("mid_rst_busy",  {31'd0, busy},      32'd0);
            step();
            rst_n = 1'b1;
            repeat (40) begin
                step();
                if (out_valid || busy) spurious++;
            end
            check("post_rst_quiet", spurious, 32'd0);
            set_op(2'b00, 3'b000, 1'b0, 1'b0, 32'd1, 32'd1);
            in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            check("post_rst_add",   result,             32'd2);
            check("post_rst_valid", {31'd0, out_valid}, 32'd1);
            step();
        end

        // 8-bit variants: iterative MUL versus MUL decoded as ADD.
        begin
            int lat8 = 0;
            int lat8n = 0;
            int busy8n_seen = 0;
            logic [7:0] r8 = '0;
            logic [7:0] r8n = '0;
            set_op(2'b10, 3'b000, 1'b0, 1'b1, 32'd0, 32'd0);
            a8 = 8'hFF; b8 = 8'h02;
            in_valid8 = 1'b1;
            step();
            in_valid8 = 1'b0;
            a8 = 8'h55; b8 = 8'hAA;
            for (int n = 1; n <= 20; n++) begin
                if (busy8n) busy8n_seen++;
                if (out_valid8 && lat8 == 0) begin lat8 = n; r8 = result8; end
                if (out_valid8n && lat8n == 0) begin lat8n = n; r8n = result8n; end
                step();
            end
            check("w8_mul_latency",  lat8,             32'd9);
            check("w8_mul_result",   {24'd0, r8},      32'h0000_00FE);
            check("w8_nomul_lat",    lat8n,            32'd1);
            check("w8_nomul_result", {24'd0, r8n},     32'h0000_0001);
            check("w8_nomul_busy",   busy8n_seen,      32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
